// File: rtl/sn_array_pkg.sv
// ---------------------------------------------------------------------------
// sn_array_pkg
// Shared definitions for the sn_network_array_top slice:
//   - local register addresses at the top of the 7-bit protocol space
//   - bank_sel_t layout of the BANK_SEL register
//   - MAX_NETWORKS: one status bit per network in an 8-bit status byte
// ---------------------------------------------------------------------------
package sn_array_pkg;

    localparam int MAX_NETWORKS = 8;

    localparam logic [6:0] ADDR_BANK_SEL    = 7'h7F;
    localparam logic [6:0] ADDR_EVAL_STATUS = 7'h7E;
    localparam logic [6:0] ADDR_EVAL_COUNT  = 7'h7D;

    typedef struct packed {
        logic       broadcast;
        logic [3:0] rsvd;
        logic [2:0] bank;
    } bank_sel_t;

endpackage

// File: rtl/sn_eval_monitor.sv
// ---------------------------------------------------------------------------
// sn_eval_monitor
// Watches one network's nc_evaluate_out level. Keeps one registered copy of
// the level for rising-edge detection, a sticky "evaluate seen" bit and,
// when SN_ARRAY_EVAL_CNT_EN is defined, a saturating rise counter.
// Clears take effect before the rise of the same cycle, so a rise coinciding
// with a read-to-clear leaves sticky=1 / count=1.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-low reset
//   evaluate      in   network evaluate level
//   clear_sticky  in   clear sticky bit this cycle
//   clear_cnt     in   clear counter this cycle
//   sticky        out  sticky rising-edge flag
//   count         out  saturating rise count (0 without SN_ARRAY_EVAL_CNT_EN)
// ---------------------------------------------------------------------------
module sn_eval_monitor #(
    parameter int P_EVAL_CNT_BW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     evaluate,
    input  logic                     clear_sticky,
    input  logic                     clear_cnt,
    output logic                     sticky,
    output logic [P_EVAL_CNT_BW-1:0] count
);

    logic evaluate_p1;
    logic rise;

    assign rise = evaluate & ~evaluate_p1;

    // Stage p1: edge register and sticky flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            evaluate_p1 <= 1'b0;
            sticky      <= 1'b0;
        end else begin
            evaluate_p1 <= evaluate;
            sticky      <= (sticky & ~clear_sticky) | rise;
        end
    end

`ifdef SN_ARRAY_EVAL_CNT_EN
    function automatic logic [P_EVAL_CNT_BW-1:0] sat_inc(input logic [P_EVAL_CNT_BW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [P_EVAL_CNT_BW-1:0] cnt_base;

    assign cnt_base = clear_cnt ? '0 : count;

    // Stage p1: rise counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (rise) begin
            count <= sat_inc(cnt_base);
        end else begin
            count <= cnt_base;
        end
    end
`else
    logic unused_clear_cnt;

    assign unused_clear_cnt = clear_cnt;
    assign count            = '0;
`endif

endmodule

// File: rtl/sn_network_array_top.sv
// ---------------------------------------------------------------------------
// sn_network_array_top
// One sn_io_protocol front end fanned out to P_NUM_NETWORKS sn_network
// instances. Addresses 0x7D..0x7F are local registers; everything below is
// forwarded to the bank selected in BANK_SEL (or to all networks on a
// broadcast write).
//   0x7F BANK_SEL    RW  [2:0] bank, [7] broadcast; bad bank sets sticky ERR
//   0x7E EVAL_STATUS RO  per-network sticky evaluate rise, [7] ERR; read-clears
//   0x7D EVAL_COUNT  RO  selected bank's rise count; read-clears
// Optional feature macro: SN_ARRAY_EVAL_CNT_EN builds the per-network
// counters; without it 0x7D reads 0x00.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   prot_enable/r0w1/addr/wdata  upstream access, prot_rdata combinational
//   net_prot_enable          per-network strobe
//   net_prot_r0w1/addr/wdata shared forwarded fields
//   net_prot_rdata           per-network read data
//   net_evaluate             per-network evaluate level
//   irq_eval                 high while any EVAL_STATUS bit is set
// ---------------------------------------------------------------------------
module sn_network_array_top
    import sn_array_pkg::*;
#(
    parameter int P_NUM_NETWORKS = 4,
    parameter int P_ADDR_BW      = 7,
    parameter int P_DATA_BW      = 8,
    parameter int P_EVAL_CNT_BW  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     prot_enable,
    input  logic                                     prot_r0w1,
    input  logic [P_ADDR_BW-1:0]                     prot_addr,
    input  logic [P_DATA_BW-1:0]                     prot_wdata,
    output logic [P_DATA_BW-1:0]                     prot_rdata,
    output logic [P_NUM_NETWORKS-1:0]                net_prot_enable,
    output logic                                     net_prot_r0w1,
    output logic [P_ADDR_BW-1:0]                     net_prot_addr,
    output logic [P_DATA_BW-1:0]                     net_prot_wdata,
    input  logic [P_NUM_NETWORKS-1:0][P_DATA_BW-1:0] net_prot_rdata,
    input  logic [P_NUM_NETWORKS-1:0]                net_evaluate,
    output logic                                     irq_eval
);

    bank_sel_t                bank_sel;
    logic                     err;
    logic                     err_vis;

    logic                     access;
    logic                     hit_bank;
    logic                     hit_status;
    logic                     hit_count;
    logic                     is_local;
    logic                     rd_status;
    logic                     rd_count;
    logic                     wr_bank;
    logic                     bank_invalid;

    logic [P_NUM_NETWORKS-1:0] bank_onehot;
    logic [P_DATA_BW-1:0]      sel_rdata;
    logic [P_EVAL_CNT_BW-1:0]  sel_count;
    logic [P_NUM_NETWORKS-1:0] sticky_vec;
    logic [P_NUM_NETWORKS-1:0] clear_cnt_vec;
    logic [P_EVAL_CNT_BW-1:0]  eval_count [P_NUM_NETWORKS];
    logic [7:0]                status_byte;

    // Accesses presented while reset is asserted are dropped.
    assign access       = prot_enable & rst;
    assign hit_bank     = (prot_addr == P_ADDR_BW'(ADDR_BANK_SEL));
    assign hit_status   = (prot_addr == P_ADDR_BW'(ADDR_EVAL_STATUS));
    assign hit_count    = (prot_addr == P_ADDR_BW'(ADDR_EVAL_COUNT));
    assign is_local     = (prot_addr >= P_ADDR_BW'(ADDR_EVAL_COUNT));
    assign rd_status    = access & ~prot_r0w1 & hit_status;
    assign rd_count     = access & ~prot_r0w1 & hit_count;
    assign wr_bank      = access & prot_r0w1 & hit_bank;
    assign bank_invalid = (32'(prot_wdata[2:0]) >= P_NUM_NETWORKS);

    // ERR only has a home in the status byte when bit 7 is not a network.
    assign err_vis  = (P_NUM_NETWORKS < MAX_NETWORKS) ? err : 1'b0;
    assign irq_eval = (|sticky_vec) | err_vis;

    assign net_prot_r0w1  = prot_r0w1;
    assign net_prot_addr  = prot_addr;
    assign net_prot_wdata = prot_wdata;

    // Bank selection: loop compare avoids indexing with a wider-than-needed bank field.
    always_comb begin
        bank_onehot = '0;
        sel_rdata   = '0;
        sel_count   = '0;
        for (int i = 0; i < P_NUM_NETWORKS; i++) begin
            if (bank_sel.bank == 3'(i)) begin
                bank_onehot[i] = 1'b1;
                sel_rdata      = net_prot_rdata[i];
                sel_count      = eval_count[i];
            end
        end
    end

    always_comb begin
        status_byte = '0;
        for (int i = 0; i < P_NUM_NETWORKS; i++) begin
            status_byte[i] = sticky_vec[i];
        end
        status_byte[7] = status_byte[7] | err_vis;
    end

    always_comb begin
        net_prot_enable = '0;
        if (access && !is_local) begin
            net_prot_enable = (prot_r0w1 && bank_sel.broadcast) ? '1 : bank_onehot;
        end
    end

    always_comb begin
        prot_rdata = '0;
        if (prot_enable && !prot_r0w1) begin
            if (hit_bank) begin
                prot_rdata = P_DATA_BW'(bank_sel);
            end else if (hit_status) begin
                prot_rdata = P_DATA_BW'(status_byte);
            end else if (hit_count) begin
                prot_rdata = P_DATA_BW'(sel_count);
            end else begin
                prot_rdata = sel_rdata;
            end
        end
    end

    assign clear_cnt_vec = rd_count ? bank_onehot : '0;

    // Stage p1: BANK_SEL and ERR
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_sel <= '0;
            err      <= 1'b0;
        end else begin
            if (rd_status) begin
                err <= 1'b0;
            end
            if (wr_bank) begin
                if (bank_invalid) begin
                    err <= 1'b1;
                end else begin
                    bank_sel.broadcast <= prot_wdata[7];
                    bank_sel.rsvd      <= 4'h0;
                    bank_sel.bank      <= prot_wdata[2:0];
                end
            end
        end
    end

    for (genvar g = 0; g < P_NUM_NETWORKS; g++) begin : g_mon
        sn_eval_monitor #(
            .P_EVAL_CNT_BW (P_EVAL_CNT_BW)
        ) u_mon (
            .clk          (clk),
            .rst          (rst),
            .evaluate     (net_evaluate[g]),
            .clear_sticky (rd_status),
            .clear_cnt    (clear_cnt_vec[g]),
            .sticky       (sticky_vec[g]),
            .count        (eval_count[g])
        );
    end

endmodule

// File: tb/tb_sn_network_array_top.sv
module tb_sn_network_array_top;

    logic            clk = 1'b0;
    logic            rst;
    logic            prot_enable;
    logic            prot_r0w1;
    logic [6:0]      prot_addr;
    logic [7:0]      prot_wdata;
    logic [7:0]      prot_rdata;
    logic [3:0]      net_prot_enable;
    logic            net_prot_r0w1;
    logic [6:0]      net_prot_addr;
    logic [7:0]      net_prot_wdata;
    logic [3:0][7:0] net_prot_rdata;
    logic [3:0]      net_evaluate;
    logic            irq_eval;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sn_network_array_top #(
        .P_NUM_NETWORKS (4),
        .P_ADDR_BW      (7),
        .P_DATA_BW      (8),
        .P_EVAL_CNT_BW  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .prot_enable     (prot_enable),
        .prot_r0w1       (prot_r0w1),
        .prot_addr       (prot_addr),
        .prot_wdata      (prot_wdata),
        .prot_rdata      (prot_rdata),
        .net_prot_enable (net_prot_enable),
        .net_prot_r0w1   (net_prot_r0w1),
        .net_prot_addr   (net_prot_addr),
        .net_prot_wdata  (net_prot_wdata),
        .net_prot_rdata  (net_prot_rdata),
        .net_evaluate    (net_evaluate),
        .irq_eval        (irq_eval)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one access at the falling edge; it commits on the next rising edge.
    // Outputs are sampled 1ns after driving, well away from the rising edge.
    task automatic access(input logic w, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        prot_enable = 1'b1;
        prot_r0w1   = w;
        prot_addr   = a;
        prot_wdata  = d;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prot_enable = 1'b0;
            prot_r0w1   = 1'b0;
            prot_addr   = 7'h00;
            prot_wdata  = 8'h00;
        end
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        prot_enable    = 1'b0;
        prot_r0w1      = 1'b0;
        prot_addr      = 7'h00;
        prot_wdata     = 8'h00;
        net_evaluate   = 4'h0;
        net_prot_rdata = {8'h44, 8'h33, 8'h22, 8'h11};
        idle(3);
        chk("reset_irq", 32'(irq_eval), 0);
        chk("reset_rdata_idle", 32'(prot_rdata), 0);
        @(negedge clk);
        rst = 1'b1;

        // Bank select and forwarded read
        access(1'b0, 7'h7F, 8'h00);
        chk("bank_sel_reset", 32'(prot_rdata), 32'h00);
        chk("local_rd_no_fwd", 32'(net_prot_enable), 0);
        access(1'b1, 7'h7F, 8'h02);
        chk("local_wr_no_fwd", 32'(net_prot_enable), 0);
        access(1'b0, 7'h7F, 8'h00);
        chk("bank_sel_rd_02", 32'(prot_rdata), 32'h02);
        access(1'b0, 7'h10, 8'h00);
        chk("fwd_rd_en_bank2", 32'(net_prot_enable), 32'b0100);
        chk("fwd_rd_data_net2", 32'(prot_rdata), 32'h33);
        chk("fwd_rd_addr", 32'(net_prot_addr), 32'h10);
        idle(1);
        prot_addr = 7'h10;
        #1;
        chk("idle_no_enable", 32'(net_prot_enable), 0);

        // Reserved bits read back zero
        access(1'b1, 7'h7F, 8'h79);
        access(1'b0, 7'h7F, 8'h00);
        chk("bank_sel_rsvd_zero", 32'(prot_rdata), 32'h01);
        access(1'b0, 7'h30, 8'h00);
        chk("fwd_rd_data_net1", 32'(prot_rdata), 32'h22);

        // Broadcast write
        access(1'b1, 7'h7F, 8'h80);
        access(1'b1, 7'h20, 8'h5A);
        chk("bcast_wr_en", 32'(net_prot_enable), 32'b1111);
        chk("bcast_wr_data", 32'(net_prot_wdata), 32'h5A);
        chk("bcast_wr_r0w1", 32'(net_prot_r0w1), 1);
        access(1'b0, 7'h20, 8'h00);
        chk("bcast_rd_en_onehot", 32'(net_prot_enable), 32'b0001);
        chk("bcast_rd_data_net0", 32'(prot_rdata), 32'h11);

        // Invalid bank write
        access(1'b1, 7'h7F, 8'h05);
        access(1'b0, 7'h7F, 8'h00);
        chk("bad_bank_unchanged", 32'(prot_rdata), 32'h80);
        chk("err_irq", 32'(irq_eval), 1);
        access(1'b1, 7'h7E, 8'hFF);
        access(1'b0, 7'h7E, 8'h00);
        chk("err_status_bit7", 32'(prot_rdata), 32'h80);
        access(1'b0, 7'h7E, 8'h00);
        chk("err_status_cleared", 32'(prot_rdata), 32'h00);
        idle(1);
        chk("err_irq_cleared", 32'(irq_eval), 0);

        // Held evaluate level on net3 counts once
        @(negedge clk);
        net_evaluate[3] = 1'b1;
        idle(3);
        chk("eval3_irq", 32'(irq_eval), 1);
        access(1'b0, 7'h7E, 8'h00);
        chk("eval3_status", 32'(prot_rdata), 32'h08);
        idle(2);
        access(1'b0, 7'h7E, 8'h00);
        chk("eval3_held_once", 32'(prot_rdata), 32'h00);
        @(negedge clk);
        net_evaluate[3] = 1'b0;
        prot_enable     = 1'b0;
        #1;
        chk("eval3_irq_cleared", 32'(irq_eval), 0);

        // Rise on net1 coinciding with a read-to-clear
        access(1'b0, 7'h7E, 8'h00);
        net_evaluate[1] = 1'b1;
        #1;
        chk("coinc_read_old", 32'(prot_rdata), 32'h00);
        access(1'b0, 7'h7E, 8'h00);
        chk("coinc_bit1_kept", 32'(prot_rdata), 32'h02);
        access(1'b0, 7'h7E, 8'h00);
        chk("coinc_bit1_cleared", 32'(prot_rdata), 32'h00);
        @(negedge clk);
        net_evaluate[1] = 1'b0;
        prot_enable     = 1'b0;

        // 300 rises on bank 0
        access(1'b1, 7'h7F, 8'h00);
        idle(1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            net_evaluate[0] = 1'b1;
            @(negedge clk);
            net_evaluate[0] = 1'b0;
        end
        idle(1);
        access(1'b0, 7'h7D, 8'h00);
`ifdef SN_ARRAY_EVAL_CNT_EN
        chk("count_saturated", 32'(prot_rdata), 32'hFF);
`else
        chk("count_absent_zero", 32'(prot_rdata), 32'h00);
`endif
        chk("count_rd_no_fwd", 32'(net_prot_enable), 0);
        access(1'b0, 7'h7D, 8'h00);
        chk("count_cleared", 32'(prot_rdata), 32'h00);
        access(1'b0, 7'h7E, 8'h00);
        chk("count_sticky_bit0", 32'(prot_rdata), 32'h01);

        // Reset asserted mid-access
        access(1'b1, 7'h7F, 8'h83);
        access(1'b0, 7'h7F, 8'h00);
        chk("pre_reset_bank", 32'(prot_rdata), 32'h83);
        access(1'b1, 7'h20, 8'hA5);
        rst = 1'b0;
        #1;
        chk("reset_gates_fwd", 32'(net_prot_enable), 0);
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 7'h7F, 8'h00);
        chk("post_reset_bank", 32'(prot_rdata), 32'h00);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
